tile_addr_gen: RTL and testbench

- Parametrised 2x2 output-tile address generator for the matrix-multiply datapath.
- Each beat carries four operand addresses: two A rows (i, i+1) and two B columns (j, j+1) at dot-product index k.
- Generalises the fixed 8x8 generator:
  - M/N/K dimensions and address width are parameters.
  - Base addresses and A/B storage layout are selected at runtime.
  - Start/done control and a valid/ready output handshake are added.
- Sits between the control FSM (start/done) and the A/B operand memories plus MAC array (consumes beats).

---
 rtl/tile_addr_gen.sv | 213 +++++++++++++++++++++
 tb/tb_tile_addr_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tile_addr_gen.sv
// 2x2 output-tile operand address generator for the matmul datapath.
// Walks k innermost, then j, then i; emits four registered A/B addresses per beat.
module tile_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int M_DIM  = 8,
    parameter int N_DIM  = 8,
    parameter int K_DIM  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_W-1:0]       base_a,
    input  logic [ADDR_W-1:0]       base_b,
    input  logic                    a_colmaj,
    input  logic                    b_colmaj,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [ADDR_W-1:0]       addr_a0,
    output logic [ADDR_W-1:0]       addr_a1,
    output logic [ADDR_W-1:0]       addr_b0,
    output logic [ADDR_W-1:0]       addr_b1,
    output logic [$clog2(M_DIM):0]  tile_i,
    output logic [$clog2(N_DIM):0]  tile_j,
    output logic                    k_first,
    output logic                    k_last,
    output logic                    busy,
    output logic                    done
);

    localparam int IW = $clog2(M_DIM) + 1;
    localparam int JW = $clog2(N_DIM) + 1;
    localparam int KW = $clog2(K_DIM) + 1;

    localparam logic [IW-1:0] I_LAST = IW'(M_DIM - 2);
    localparam logic [JW-1:0] J_LAST = JW'(N_DIM - 2);
    localparam logic [KW-1:0] K_LAST = KW'(K_DIM - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic [JW-1:0]       j_q, j_d;
    logic [KW-1:0]       k_q, k_d;
    logic [ADDR_W-1:0]   base_a_q, base_a_d;
    logic [ADDR_W-1:0]   base_b_q, base_b_d;
    logic                a_colmaj_q, a_colmaj_d;
    logic                b_colmaj_q, b_colmaj_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   a0_q, a0_d, a1_q, a1_d;
    logic [ADDR_W-1:0]   b0_q, b0_d, b1_q, b1_d;
    logic                k_first_q, k_first_d;
    logic                k_last_q, k_last_d;
    logic                done_q, done_d;

    logic                fire, last_beat, load_beat, clear_run;
    logic [ADDR_W-1:0]   ext_i, ext_j, ext_k, a0_n, b0_n;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        base_a_d   = base_a_q;
        base_b_d   = base_b_q;
        a_colmaj_d = a_colmaj_q;
        b_colmaj_d = b_colmaj_q;
        valid_d    = valid_q;
        a0_d       = a0_q;
        a1_d       = a1_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        k_first_d  = k_first_q;
        k_last_d   = k_last_q;
        done_d     = 1'b0;
        load_beat  = 1'b0;
        clear_run  = 1'b0;

        fire      = valid_q && out_ready;
        last_beat = (i_q == I_LAST) && (j_q == J_LAST) && (k_q == K_LAST);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    base_a_d   = base_a;
                    base_b_d   = base_b;
                    a_colmaj_d = a_colmaj;
                    b_colmaj_d = b_colmaj;
                    i_d        = '0;
                    j_d        = '0;
                    k_d        = '0;
                    state_d    = RUN;
                    load_beat  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    clear_run = 1'b1;
                end else if (fire) begin
                    if (last_beat) begin
                        state_d   = IDLE;
                        clear_run = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        load_beat = 1'b1;
                        if (k_q == K_LAST) begin
                            k_d = '0;
                            if (j_q == J_LAST) begin
                                j_d = '0;
                                i_d = i_q + IW'(2);
                            end else begin
                                j_d = j_q + JW'(2);
                            end
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_run) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end

        // Addresses for the beat being loaded, from the next counters and latched modes.
        ext_i = ADDR_W'(i_d);
        ext_j = ADDR_W'(j_d);
        ext_k = ADDR_W'(k_d);
        a0_n  = a_colmaj_d ? base_a_d + ext_k * ADDR_W'(M_DIM) + ext_i
                           : base_a_d + ext_i * ADDR_W'(K_DIM) + ext_k;
        b0_n  = b_colmaj_d ? base_b_d + ext_j * ADDR_W'(K_DIM) + ext_k
                           : base_b_d + ext_k * ADDR_W'(N_DIM) + ext_j;

        if (load_beat) begin
            valid_d   = 1'b1;
            a0_d      = a0_n;
            a1_d      = a0_n + (a_colmaj_d ? ADDR_W'(1) : ADDR_W'(K_DIM));
            b0_d      = b0_n;
            b1_d      = b0_n + (b_colmaj_d ? ADDR_W'(K_DIM) : ADDR_W'(1));
            k_first_d = (k_d == '0);
            k_last_d  = (k_d == K_LAST);
        end else if (clear_run) begin
            valid_d   = 1'b0;
            a0_d      = '0;
            a1_d      = '0;
            b0_d      = '0;
            b1_d      = '0;
            k_first_d = 1'b0;
            k_last_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            base_a_q   <= '0;
            base_b_q   <= '0;
            a_colmaj_q <= 1'b0;
            b_colmaj_q <= 1'b0;
            valid_q    <= 1'b0;
            a0_q       <= '0;
            a1_q       <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            k_first_q  <= 1'b0;
            k_last_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            base_a_q   <= base_a_d;
            base_b_q   <= base_b_d;
            a_colmaj_q <= a_colmaj_d;
            b_colmaj_q <= b_colmaj_d;
            valid_q    <= valid_d;
            a0_q       <= a0_d;
            a1_q       <= a1_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            k_first_q  <= k_first_d;
            k_last_q   <= k_last_d;
            done_q     <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign addr_a0   = a0_q;
    assign addr_a1   = a1_q;
    assign addr_b0   = b0_q;
    assign addr_b1   = b1_q;
    assign tile_i    = i_q;
    assign tile_j    = j_q;
    assign k_first   = k_first_q;
    assign k_last    = k_last_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Directed bench for tile_addr_gen at default 8x8x8 geometry, ADDR_W=8.
module tb_tile_addr_gen;

    logic       clk, reset, start, abort, a_colmaj, b_colmaj, out_ready;
    logic [7:0] base_a, base_b;
    logic       out_valid, k_first, k_last, busy, done;
    logic [7:0] addr_a0, addr_a1, addr_b0, addr_b1;
    logic [3:0] tile_i, tile_j;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    tile_addr_gen dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_a(base_a), .base_b(base_b), .a_colmaj(a_colmaj), .b_colmaj(b_colmaj),
        .out_ready(out_ready), .out_valid(out_valid),
        .addr_a0(addr_a0), .addr_a1(addr_a1), .addr_b0(addr_b0), .addr_b1(addr_b1),
        .tile_i(tile_i), .tile_j(tile_j), .k_first(k_first), .k_last(k_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag,
                              input logic [31:0] a0, a1, b0, b1, ti, tj, kf, kl);
        check({tag, ".valid"},   32'(out_valid), 1);
        check({tag, ".a0"},      32'(addr_a0), a0);
        check({tag, ".a1"},      32'(addr_a1), a1);
        check({tag, ".b0"},      32'(addr_b0), b0);
        check({tag, ".b1"},      32'(addr_b1), b1);
        check({tag, ".tile_i"},  32'(tile_i), ti);
        check({tag, ".tile_j"},  32'(tile_j), tj);
        check({tag, ".k_first"}, 32'(k_first), kf);
        check({tag, ".k_last"},  32'(k_last), kl);
    endtask

    // Walks a run from beat 0 to completion with out_ready held high.
    task automatic run_to_done(input string tag, input logic [31:0] last_a0, last_a1);
        int beats = 0;
        int dones = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                dones++;
                check({tag, ".done_after_beat127"}, 32'(beats), 128);
                check({tag, ".valid_on_done"}, 32'(out_valid), 0);
            end
            if (out_valid && out_ready) begin
                if (beats == 8) begin
                    check({tag, ".b8.b0"}, 32'(addr_b0), 16);
                    check({tag, ".b8.b1"}, 32'(addr_b1), 24);
                    check({tag, ".b8.tile_j"}, 32'(tile_j), 2);
                    check({tag, ".b8.k_first"}, 32'(k_first), 1);
                end
                if (beats == 127)
                    check_beat({tag, ".b127"}, last_a0, last_a1, 55, 63, 6, 6, 0, 1);
                beats++;
            end
            tick();
        end
        check({tag, ".handshakes"}, 32'(beats), 128);
        check({tag, ".done_pulses"}, 32'(dones), 1);
        check({tag, ".busy_end"}, 32'(busy), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_a = '0; base_b = '0; a_colmaj = 1'b0; b_colmaj = 1'b0;
        tick(); tick();

        check("rst.valid", 32'(out_valid), 0);
        check("rst.a0", 32'(addr_a0), 0);
        check("rst.a1", 32'(addr_a1), 0);
        check("rst.b0", 32'(addr_b0), 0);
        check("rst.b1", 32'(addr_b1), 0);
        check("rst.tiles", 32'({tile_i, tile_j}), 0);
        check("rst.kflags", 32'({k_first, k_last}), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        reset = 1'b0;
        tick();

        // Full column-major run.
        a_colmaj = 1'b1; b_colmaj = 1'b1; out_ready = 1'b1;
        pulse_start();
        check_beat("cm.b0", 0, 1, 0, 8, 0, 0, 1, 0);
        check("cm.busy", 32'(busy), 1);
        run_to_done("cm", 62, 63);

        // Row-major layouts with nonzero bases.
        base_a = 8'h10; base_b = 8'h80; a_colmaj = 1'b0; b_colmaj = 1'b0;
        pulse_start();
        check_beat("rm.b0", 'h10, 'h18, 'h80, 'h81, 0, 0, 1, 0);
        tick();
        check_beat("rm.b1", 'h11, 'h19, 'h88, 'h89, 0, 0, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("rm.abort.valid", 32'(out_valid), 0);

        // Backpressure at beat 3, then abort at beat 40.
        base_a = '0; base_b = '0; a_colmaj = 1'b1; b_colmaj = 1'b1;
        pulse_start();
        tick(); tick(); tick();
        check_beat("bp.b3", 24, 25, 3, 11, 0, 0, 0, 0);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_beat("bp.hold", 24, 25, 3, 11, 0, 0, 0, 0);
        end
        out_ready = 1'b1;
        tick();
        check_beat("bp.b4", 32, 33, 4, 12, 0, 0, 0, 0);
        tick();
        check_beat("bp.b5", 40, 41, 5, 13, 0, 0, 0, 0);
        for (int c = 0; c < 35; c++) tick();
        check_beat("bp.b40", 2, 3, 16, 24, 2, 2, 1, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab.valid", 32'(out_valid), 0);
        check("ab.busy", 32'(busy), 0);
        check("ab.done", 32'(done), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("ab.no_done", 32'({done, out_valid}), 0);
        end

        // Abort beats start in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("idle_abort.busy", 32'(busy), 0);
        check("idle_abort.valid", 32'(out_valid), 0);

        // Restart after abort with wrapping base_a.
        base_a = 8'd250;
        pulse_start();
        check_beat("wrap.b0", 250, 251, 0, 8, 0, 0, 1, 0);
        run_to_done("wrap", 56, 57);

        // Start held through RUN, then reset mid-run.
        base_a = '0;
        start = 1'b1;
        tick();
        check_beat("hs.b0", 0, 1, 0, 8, 0, 0, 1, 0);
        tick(); tick();
        check_beat("hs.b2", 16, 17, 2, 10, 0, 0, 0, 0);
        tick();
        check_beat("hs.b3", 24, 25, 3, 11, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("mrst.valid", 32'(out_valid), 0);
        check("mrst.addrs", {addr_a0, addr_a1, addr_b0, addr_b1}, 0);
        check("mrst.tiles", 32'({tile_i, tile_j}), 0);
        check("mrst.kflags", 32'({k_first, k_last}), 0);
        check("mrst.busy_done", 32'({busy, done}), 0);
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("mrst.after", 32'({busy, done, out_valid}), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
